// File: rtl/count_sequencer.sv
// Run/pause/direction sequencer that paces an external up/down counter from a tick.
// Optional macro AUTO_REVERSE_EN: reverse direction at a limit instead of stopping in DONE.

// Button conditioner: 2-flop synchronizer plus rising-edge detector, one pulse per press.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse_c
);

  logic       meta;
  logic       sync;
  logic       last;
  logic       armed;
  logic [1:0] warm;

  // armed only after a genuine low sample, so a button held through reset stays silent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      last  <= 1'b0;
      armed <= 1'b0;
      warm  <= 2'b00;
    end else begin
      meta <= btn;
      sync <= meta;
      last <= sync;
      warm <= {warm[0], 1'b1};
      if (warm[1] && !sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign pulse_c = sync & ~last & armed;

endmodule

module count_sequencer #(
  parameter int unsigned BIT_COUNT = 12,
  parameter int unsigned MAX_VAL   = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 btn_run,
  input  logic                 btn_dir,
  input  logic [BIT_COUNT-1:0] cnt,
  output logic                 ena,
  output logic                 updn,
  output logic                 at_limit,
  output logic [1:0]           state
);

  localparam logic [BIT_COUNT-1:0] MAX_CNT = BIT_COUNT'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t state_q;
  state_t state_n;
  logic   updn_q;
  logic   updn_n;
  logic   ena_q;
  logic   ena_n;
  logic   run_p;
  logic   dir_p;
  logic   lim_up;
  logic   lim_dn;

  btn_pulse u_run (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_run),
    .pulse_c (run_p)
  );

  btn_pulse u_dir (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_dir),
    .pulse_c (dir_p)
  );

  // values beyond MAX_VAL count as the upper limit so an upward count can never overshoot
  assign lim_up   = (cnt >= MAX_CNT);
  assign lim_dn   = (cnt == '0);
  assign at_limit = updn_q ? lim_up : lim_dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      updn_q  <= 1'b1;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      updn_q  <= updn_n;
      ena_q   <= ena_n;
    end
  end

  always_comb begin
    state_n = state_q;
    updn_n  = updn_q;
    ena_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_p) state_n = RUN;
        if (dir_p) updn_n = ~updn_q;
      end
      RUN: begin
        if (tick && at_limit) begin
          // limit handling overrides any direction press in the same cycle
`ifdef AUTO_REVERSE_EN
          updn_n = ~updn_q;
          if (run_p) state_n = PAUSE;
`else
          state_n = DONE;
`endif
        end else begin
          if (run_p) state_n = PAUSE;
          if (dir_p) updn_n = ~updn_q;
          // judge the limit against the direction the counter will actually use
          ena_n = tick && !(updn_n ? lim_up : lim_dn);
        end
      end
      PAUSE: begin
        if (run_p) state_n = RUN;
        if (dir_p) updn_n = ~updn_q;
      end
      DONE: begin
        if (dir_p) begin
          updn_n  = ~updn_q;
          state_n = PAUSE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ena   = ena_q;
  assign updn  = updn_q;
  assign state = state_q;

endmodule
